filter_allocator: RTL and testbench

FILTER_ALLOCATOR -- requirements
Module: filter_allocator

---
 rtl/filter_allocator_if.sv | 21 ++
 rtl/filter_allocator.sv | 114 +++++++++++
 tb/tb_filter_allocator.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/filter_allocator_if.sv
// Broadcast weight bus from the filter issuer and the weight stream toward the DSP.
interface filter_allocator_if;
  logic [12:0] filter_issue_counter;
  logic [17:0] filter_data;
  logic        filter_en;
  logic        filter_block;
  logic [17:0] w_data;
  logic [12:0] w_index;
  logic        w_valid;
  logic        w_ready;

  modport master (
    output filter_issue_counter, filter_data, filter_en, w_ready,
    input  filter_block, w_data, w_index, w_valid
  );

  modport slave (
    input  filter_issue_counter, filter_data, filter_en, w_ready,
    output filter_block, w_data, w_index, w_valid
  );
endinterface

// File: rtl/filter_allocator.sv
// Captures the broadcast weights whose counter falls inside this allocator's window
// and replays them in capture order through a first-word fall-through FIFO.
module filter_allocator #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [12:0]         win_base,
  input  logic [12:0]         win_len,
  filter_allocator_if.slave   bus,
  output logic                done,
  output logic                overflow
);

  localparam int unsigned CNT_W  = 13;
  localparam int unsigned DATA_W = 18;
  localparam int unsigned ENT_W  = CNT_W + DATA_W;
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned OCC_W  = AW + 1;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic               load_c;
  logic [CNT_W-1:0]   base_q, len_q, cnt_q, cnt_inc;
  logic [ENT_W-1:0]   mem [DEPTH];
  logic [ENT_W-1:0]   head;
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [OCC_W-1:0]   occ;
  logic [CNT_W:0]     ctr_ext, lo_ext, hi_ext;
  logic               capture, empty, full, pop, push;

  // Window test is done one bit wider so base+len never wraps.
  assign ctr_ext = {1'b0, bus.filter_issue_counter};
  assign lo_ext  = {1'b0, base_q};
  assign hi_ext  = {1'b0, base_q} + {1'b0, len_q};
  assign capture = (state_q == COLLECT) && bus.filter_en &&
                   (ctr_ext >= lo_ext) && (ctr_ext < hi_ext);

  assign empty   = (occ == '0);
  assign full    = (occ == OCC_W'(DEPTH));
  assign pop     = !empty && bus.w_ready;
  assign push    = capture && (!full || pop);
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Round sequencing.
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          load_c  = 1'b1;
          state_d = (win_len == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        if (capture && (cnt_inc == len_q)) state_d = DRAIN;
      end
      DRAIN: begin
        if (empty || ((occ == OCC_W'(1)) && pop)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Window registers, capture count, FIFO pointers/occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      overflow <= 1'b0;
    end else begin
      if (load_c) begin
        base_q <= win_base;
        len_q  <= win_len;
        cnt_q  <= '0;
      end else if (capture) begin
        cnt_q  <= cnt_inc;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
      if (capture && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= {CNT_W'(bus.filter_issue_counter - base_q), bus.filter_data};
  end

  assign head             = mem[rd_ptr];
  assign bus.w_index      = head[ENT_W-1:DATA_W];
  assign bus.w_data       = head[DATA_W-1:0];
  assign bus.w_valid      = !empty;
  assign done             = (state_q == DONE);
  // Two-entry margin absorbs the beat already in flight from the issuer.
  assign bus.filter_block = (state_q == COLLECT) && (occ >= OCC_W'(DEPTH - 2));

endmodule

// File: tb/tb_filter_allocator.sv
// Directed bench for filter_allocator: queue-based reference model checked every
// cycle, plus literal expectations for the scenario outcomes.
module tb_filter_allocator;
  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [12:0] win_base, win_len;
  logic        done, overflow;
  bit          chk_en = 1'b0;
  int          checks = 0;
  int          errors = 0;

  filter_allocator_if bus();

  filter_allocator #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .win_base (win_base),
    .win_len  (win_len),
    .bus      (bus.slave),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [17:0] wt(input int c);
    return 18'(c * 7 + 100);
  endfunction

  // Reference model: phase 0=idle 1=collect 2=drain 3=done; FIFO is a plain queue.
  int          m_phase, m_base, m_len, m_cnt;
  bit          m_ovf;
  logic [30:0] mq[$];
  logic [30:0] pop_log[$];

  always @(posedge clk) begin
    int ctr, sz;
    bit pop, cap;
    if (rst) begin
      mq.delete();
      m_phase = 0;
      m_cnt   = 0;
      m_ovf   = 1'b0;
    end else begin
      ctr = int'(bus.filter_issue_counter);
      sz  = mq.size();
      pop = (sz > 0) && (bus.w_ready === 1'b1);
      cap = (m_phase == 1) && (bus.filter_en === 1'b1) && (ctr >= m_base) && (ctr < m_base + m_len);
      if (pop) pop_log.push_back(mq.pop_front());
      if (cap) begin
        if (sz < DEPTH || pop) mq.push_back({13'(ctr - m_base), bus.filter_data});
        else m_ovf = 1'b1;
        m_cnt++;
      end
      if ((m_phase == 0 || m_phase == 3) && start) begin
        m_base  = int'(win_base);
        m_len   = int'(win_len);
        m_cnt   = 0;
        m_phase = (win_len == 13'd0) ? 3 : 1;
      end else if (m_phase == 1 && m_cnt == m_len) begin
        m_phase = 2;
      end else if (m_phase == 2 && mq.size() == 0) begin
        m_phase = 3;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("w_valid", bus.w_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        check("w_index", bus.w_index, mq[0][30:18]);
        check("w_data", bus.w_data, mq[0][17:0]);
      end
      check("done", done, m_phase == 3);
      check("overflow", overflow, m_ovf);
      check("filter_block", bus.filter_block, (m_phase == 1) && (mq.size() >= DEPTH - 2));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int c, input bit en);
    bus.filter_issue_counter = 13'(c);
    bus.filter_data          = wt(c);
    bus.filter_en            = en;
    cyc();
    bus.filter_en            = 1'b0;
  endtask

  task automatic arm(input int b, input int l);
    win_base = 13'(b);
    win_len  = 13'(l);
    start    = 1'b1;
    cyc();
    start    = 1'b0;
  endtask

  task automatic wait_done(input string name, input int maxc);
    int n = 0;
    while (done !== 1'b1 && n < maxc) begin
      cyc();
      n++;
    end
    check(name, done, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int c, pk, p0;
    logic blk_prev, en;
    int exp_w[3];
    exp_w = '{128, 135, 142};

    rst = 1'b1; start = 1'b0; win_base = '0; win_len = '0;
    bus.filter_en = 1'b0; bus.filter_issue_counter = '0; bus.filter_data = '0; bus.w_ready = 1'b0;
    cyc(); cyc();
    chk_en = 1'b1;
    check("rst_w_valid", bus.w_valid, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_block", bus.filter_block, 0);
    rst = 1'b0;

    // Window 4..6 out of counters 0..9.
    p0 = pop_log.size();
    bus.w_ready = 1'b1;
    arm(4, 3);
    for (int i = 0; i < 10; i++) beat(i, 1'b1);
    wait_done("r38_done", 20);
    check("r38_pops", pop_log.size() - p0, 3);
    for (int i = 0; i < 3; i++) begin
      if (p0 + i < pop_log.size()) begin
        check("r38_idx", pop_log[p0+i][30:18], i);
        check("r38_data", pop_log[p0+i][17:0], exp_w[i]);
      end
    end

    // Empty window finishes immediately.
    arm(0, 0);
    check("r40_done", done, 1);
    check("r40_valid", bus.w_valid, 0);
    cyc();
    check("r40_valid2", bus.w_valid, 0);

    // Disabled beats are not captured.
    p0 = pop_log.size();
    arm(10, 2);
    check("r43_done_clr", done, 0);
    beat(10, 1'b0);
    beat(11, 1'b0);
    check("r43_nocap", bus.w_valid, 0);
    beat(10, 1'b1);
    beat(11, 1'b1);
    wait_done("r43_done", 20);
    check("r43_pops", pop_log.size() - p0, 2);
    if (pop_log.size() >= p0 + 2) begin
      check("r43_data0", pop_log[p0][17:0], 170);
      check("r43_idx1", pop_log[p0+1][30:18], 1);
      check("r43_data1", pop_log[p0+1][17:0], 177);
    end

    // Issuer honouring filter_block with one cycle of lag.
    p0 = pop_log.size();
    bus.w_ready = 1'b0;
    arm(0, 20);
    c = 0; pk = 0; blk_prev = 1'b0;
    for (int k = 0; k < 100 && c < 20; k++) begin
      if (k == 20) begin
        check("r39_peak", pk, 7);
        check("r39_overflow", overflow, 0);
        bus.w_ready = 1'b1;
      end
      en = !blk_prev;
      blk_prev = bus.filter_block;
      bus.filter_issue_counter = 13'(c);
      bus.filter_data          = wt(c);
      bus.filter_en            = en;
      cyc();
      if (en) c++;
      if (mq.size() > pk) pk = mq.size();
    end
    bus.filter_en = 1'b0;
    check("r39_issued", c, 20);
    wait_done("r39_done", 40);
    check("r39_pops", pop_log.size() - p0, 20);

    // Full FIFO: push with simultaneous pop is kept, push without pop is dropped.
    p0 = pop_log.size();
    bus.w_ready = 1'b0;
    arm(0, 20);
    for (int i = 0; i < 8; i++) beat(i, 1'b1);
    bus.w_ready = 1'b1;
    beat(8, 1'b1);
    bus.w_ready = 1'b0;
    check("r41_ovf_pop", overflow, 0);
    beat(9, 1'b1);
    check("r41_ovf", overflow, 1);
    bus.w_ready = 1'b1;
    for (int i = 10; i < 20; i++) beat(i, 1'b1);
    wait_done("r41_done", 30);
    check("r41_pops", pop_log.size() - p0, 19);
    if (pop_log.size() >= p0 + 10) begin
      check("r41_idx8", pop_log[p0+8][30:18], 8);
      check("r41_idx9", pop_log[p0+9][30:18], 10);
    end

    // Reset mid-collect with three entries buffered, then recapture.
    bus.w_ready = 1'b0;
    arm(0, 5);
    for (int i = 0; i < 3; i++) beat(i, 1'b1);
    rst = 1'b1;
    cyc();
    check("r42_valid", bus.w_valid, 0);
    check("r42_block", bus.filter_block, 0);
    check("r42_done", done, 0);
    check("r42_ovf", overflow, 0);
    rst = 1'b0;
    p0 = pop_log.size();
    bus.w_ready = 1'b1;
    arm(0, 5);
    for (int i = 0; i < 5; i++) beat(i, 1'b1);
    wait_done("r42_done2", 20);
    check("r42_pops", pop_log.size() - p0, 5);
    if (pop_log.size() >= p0 + 5) begin
      check("r42_data0", pop_log[p0][17:0], 100);
      check("r42_idx4", pop_log[p0+4][30:18], 4);
    end

    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
